// File: rtl/adc_channel_arbiter_if.sv
// Bundle between the ADC bank/timekeeper side and the fifo_ram write side of the channel arbiter.
// master = arbiter, slave = surrounding system (ADC bank, timekeeper, fifo_ram, status consumer).
interface adc_channel_arbiter_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 16,
  parameter int TS_W   = 32
);
  localparam int PKT_W = 16 + TS_W + DATA_W;

  logic                     enable_p;
  logic                     timekeeper_ready_p;
  logic [TS_W-1:0]          timestamp_p;
  logic [NUM_CH*DATA_W-1:0] adc_data_in_p;
  logic [NUM_CH-1:0]        adc_data_received_p;
  logic                     fifo_full_p;
  logic                     fifo_wr_en_p;
  logic [PKT_W-1:0]         fifo_wr_data_p;
  logic [NUM_CH-1:0]        pending_p;
  logic [NUM_CH-1:0]        overrun_p;

  modport master (
    input  enable_p, timekeeper_ready_p, timestamp_p, adc_data_in_p,
    input  adc_data_received_p, fifo_full_p,
    output fifo_wr_en_p, fifo_wr_data_p, pending_p, overrun_p
  );

  modport slave (
    output enable_p, timekeeper_ready_p, timestamp_p, adc_data_in_p,
    output adc_data_received_p, fifo_full_p,
    input  fifo_wr_en_p, fifo_wr_data_p, pending_p, overrun_p
  );
endinterface

// File: rtl/adc_channel_arbiter.sv
// Round-robin merge of NUM_CH timestamped ADC samples into one 64-bit fifo_ram write port.
// Optional macro ADC_ARB_OVERRUN_CNT_EN adds per-channel saturating drop counters reported in flags[7:1].
module adc_channel_arbiter #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 16,
  parameter int TS_W   = 32
) (
  input  logic                  clk210_p,
  input  logic                  reset_n_p,
  adc_channel_arbiter_if.master bus
);
  localparam int PKT_W = 16 + TS_W + DATA_W;
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic {ARB_IDLE, ARB_WRITE} state_t;

  state_t              state, state_next;
  logic [CH_W-1:0]     rr_ptr;
  logic [NUM_CH-1:0]   pending, overrun, capture, drop;
  logic [DATA_W-1:0]   hold_data [NUM_CH];
  logic [TS_W-1:0]     hold_ts   [NUM_CH];

  logic                grant_p0;
  logic [CH_W-1:0]     gnt_idx_p0, idx_hi, idx_lo;
  logic                found_hi;
  logic [NUM_CH-1:0]   gnt_vec_p0;
  logic [7:0]          flags_p0;

  logic                wr_en_p1;
  logic [PKT_W-1:0]    wr_data_p1;

`ifdef ADC_ARB_OVERRUN_CNT_EN
  logic [7:0]          drop_cnt [NUM_CH];

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  function automatic logic [6:0] clamp7(input logic [7:0] c);
    return c[7] ? 7'h7F : c[6:0];
  endfunction
`endif

  assign capture = bus.adc_data_received_p & {NUM_CH{bus.timekeeper_ready_p}};
  // A grant frees the slot in the same cycle, so a coincident pulse is a capture, not a drop.
  assign drop    = capture & pending & ~gnt_vec_p0;

  assign bus.fifo_wr_en_p   = wr_en_p1;
  assign bus.fifo_wr_data_p = wr_data_p1;
  assign bus.pending_p      = pending;
  assign bus.overrun_p      = overrun;

  always_ff @(posedge clk210_p or negedge reset_n_p) begin
    if (!reset_n_p) state <= ARB_IDLE;
    else            state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ARB_IDLE:  if (grant_p0) state_next = ARB_WRITE;
      ARB_WRITE: state_next = ARB_IDLE;
    endcase
  end

  // Stage p0: pick the first pending channel at or above rr_ptr, else the lowest one below it.
  always_comb begin
    found_hi   = 1'b0;
    idx_hi     = '0;
    idx_lo     = '0;
    gnt_vec_p0 = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (pending[k]) begin
        if (k >= 32'(rr_ptr)) begin
          found_hi = 1'b1;
          idx_hi   = CH_W'(k);
        end else begin
          idx_lo   = CH_W'(k);
        end
      end
    end
    grant_p0   = (state == ARB_IDLE) && bus.enable_p && !bus.fifo_full_p && (|pending);
    gnt_idx_p0 = found_hi ? idx_hi : idx_lo;
    if (grant_p0) gnt_vec_p0[gnt_idx_p0] = 1'b1;
`ifdef ADC_ARB_OVERRUN_CNT_EN
    flags_p0 = {clamp7(drop_cnt[gnt_idx_p0]), overrun[gnt_idx_p0]};
`else
    flags_p0 = {7'd0, overrun[gnt_idx_p0]};
`endif
  end

  // Stage p1: registered write port; data holds between strobes.
  always_ff @(posedge clk210_p or negedge reset_n_p) begin
    if (!reset_n_p) begin
      wr_en_p1   <= 1'b0;
      wr_data_p1 <= '0;
      rr_ptr     <= '0;
    end else begin
      wr_en_p1 <= grant_p0;
      if (grant_p0) begin
        wr_data_p1 <= {8'(gnt_idx_p0), flags_p0, hold_ts[gnt_idx_p0], hold_data[gnt_idx_p0]};
        rr_ptr     <= (gnt_idx_p0 == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx_p0 + 1'b1;
      end
    end
  end

  always_ff @(posedge clk210_p or negedge reset_n_p) begin
    if (!reset_n_p) begin
      pending <= '0;
      overrun <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        hold_data[k] <= '0;
        hold_ts[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (capture[k] && (!pending[k] || gnt_vec_p0[k])) begin
          hold_data[k] <= bus.adc_data_in_p[k*DATA_W +: DATA_W];
          hold_ts[k]   <= bus.timestamp_p;
        end
        if (capture[k])         pending[k] <= 1'b1;
        else if (gnt_vec_p0[k]) pending[k] <= 1'b0;
        if (drop[k])            overrun[k] <= 1'b1;
        else if (gnt_vec_p0[k]) overrun[k] <= 1'b0;
      end
    end
  end

`ifdef ADC_ARB_OVERRUN_CNT_EN
  always_ff @(posedge clk210_p or negedge reset_n_p) begin
    if (!reset_n_p) begin
      for (int k = 0; k < NUM_CH; k++) drop_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (gnt_vec_p0[k])  drop_cnt[k] <= '0;
        else if (drop[k])   drop_cnt[k] <= sat_inc(drop_cnt[k]);
      end
    end
  end
`endif
endmodule

// File: tb/tb_adc_channel_arbiter.sv
// Scoreboard bench for adc_channel_arbiter: a transaction-level model predicts packets and cycle,
// a negedge monitor pops and compares whenever the write strobe is seen.
module tb_adc_channel_arbiter;
  localparam int NUM_CH = 4;
  localparam int DATA_W = 16;
  localparam int TS_W   = 32;
  localparam int PKT_W  = 16 + TS_W + DATA_W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  adc_channel_arbiter_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .TS_W(TS_W)) bus();

  adc_channel_arbiter #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .TS_W(TS_W)) dut (
    .clk210_p  (clk),
    .reset_n_p (rst_n),
    .bus       (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [PKT_W-1:0] data;
    int               cyc;
  } exp_t;
  exp_t q[$];
  exp_t mon_e;

  logic [NUM_CH-1:0] m_pend, m_ovr;
  logic [DATA_W-1:0] m_data [NUM_CH];
  logic [TS_W-1:0]   m_ts   [NUM_CH];
  int                m_cnt  [NUM_CH];
  int                m_rr, m_g;
  bit                m_busy, m_gr;
  logic [7:0]        m_fl;
  logic [PKT_W-1:0]  m_last;

  task automatic chk(input string nm, input logic [PKT_W-1:0] act, input logic [PKT_W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Reference model: one grant at most every other cycle, round-robin from the channel after the last grant.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_pend = '0;
        m_ovr  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
          m_data[k] = '0;
          m_ts[k]   = '0;
          m_cnt[k]  = 0;
        end
        m_rr   = 0;
        m_busy = 1'b0;
        m_last = '0;
        q.delete();
      end else begin
        cyc++;
        m_gr = 1'b0;
        m_g  = 0;
        if (!m_busy && bus.enable_p && !bus.fifo_full_p) begin
          for (int i = 0; i < NUM_CH; i++) begin
            if (!m_gr && m_pend[(m_rr + i) % NUM_CH]) begin
              m_gr = 1'b1;
              m_g  = (m_rr + i) % NUM_CH;
            end
          end
        end
        if (m_gr) begin
`ifdef ADC_ARB_OVERRUN_CNT_EN
          m_fl = {7'(m_cnt[m_g] > 127 ? 127 : m_cnt[m_g]), m_ovr[m_g]};
`else
          m_fl = {7'd0, m_ovr[m_g]};
`endif
          m_last = {8'(m_g), m_fl, m_ts[m_g], m_data[m_g]};
          q.push_back('{data: m_last, cyc: cyc});
          m_pend[m_g] = 1'b0;
          m_ovr[m_g]  = 1'b0;
          m_cnt[m_g]  = 0;
          m_rr        = (m_g + 1) % NUM_CH;
        end
        m_busy = m_gr;
        if (bus.timekeeper_ready_p) begin
          for (int k = 0; k < NUM_CH; k++) begin
            if (bus.adc_data_received_p[k]) begin
              if (!m_pend[k]) begin
                m_pend[k] = 1'b1;
                m_data[k] = bus.adc_data_in_p[k*DATA_W +: DATA_W];
                m_ts[k]   = bus.timestamp_p;
              end else begin
                m_ovr[k] = 1'b1;
                if (m_cnt[k] < 255) m_cnt[k]++;
              end
            end
          end
        end
      end
    end
  end

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("pending", 64'(bus.pending_p), 64'(m_pend));
        chk("overrun", 64'(bus.overrun_p), 64'(m_ovr));
        if (bus.fifo_wr_en_p) begin
          if (q.size() == 0) begin
            chk("unexpected_write", 64'(bus.fifo_wr_en_p), 64'd0);
          end else begin
            mon_e = q.pop_front();
            chk("pkt_data", bus.fifo_wr_data_p, mon_e.data);
            chk("pkt_cycle", 64'(cyc), 64'(mon_e.cyc));
          end
        end else begin
          chk("hold_data", bus.fifo_wr_data_p, m_last);
          if (q.size() > 0 && q[0].cyc <= cyc) begin
            mon_e = q.pop_front();
            chk("missing_write", 64'(bus.fifo_wr_en_p), 64'd1);
          end
        end
      end
    end
  end

  task automatic step(input logic [NUM_CH-1:0] m, input logic [TS_W-1:0] t);
    bus.adc_data_received_p = m;
    bus.timestamp_p         = t;
    @(negedge clk);
    bus.adc_data_received_p = '0;
  endtask

  task automatic rand_data();
    for (int k = 0; k < NUM_CH; k++) bus.adc_data_in_p[k*DATA_W +: DATA_W] = 16'($urandom);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  logic [DATA_W-1:0] s_a, s_b;
  bit seen;

  initial begin
    bus.enable_p            = 1'b1;
    bus.timekeeper_ready_p  = 1'b1;
    bus.fifo_full_p         = 1'b0;
    bus.adc_data_received_p = '0;
    bus.adc_data_in_p       = '0;
    bus.timestamp_p         = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_wr_en",   64'(bus.fifo_wr_en_p), 64'd0);
    chk("rst_wr_data", bus.fifo_wr_data_p,    64'd0);
    chk("rst_pending", 64'(bus.pending_p),    64'd0);
    chk("rst_overrun", 64'(bus.overrun_p),    64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // single pulse on ch2
    bus.adc_data_in_p[2*DATA_W +: DATA_W] = 16'hBEEF;
    step(4'b0100, 32'd100);
    @(negedge clk);
    chk("t1_wr_en", 64'(bus.fifo_wr_en_p), 64'd1);
    chk("t1_data",  bus.fifo_wr_data_p, {8'd2, 8'd0, 32'd100, 16'hBEEF});
    @(negedge clk);
    chk("t1_pending", 64'(bus.pending_p), 64'd0);

    // all channels at once from rr_ptr=0, then a lone ch1
    do_reset();
    rand_data();
    step(4'b1111, 32'd200);
    for (int k = 0; k < NUM_CH; k++) begin
      @(negedge clk);
      chk("t2_order", 64'(bus.fifo_wr_data_p[63:56]), 64'(k));
      @(negedge clk);
    end
    rand_data();
    step(4'b0010, 32'd300);
    @(negedge clk);
    chk("t2_ch1_now", 64'({bus.fifo_wr_en_p, bus.fifo_wr_data_p[63:56]}), 64'h101);
    repeat (2) @(negedge clk);

    // fifo full: overrun accumulates, first sample kept
    bus.fifo_full_p = 1'b1;
    s_a = 16'h1234;
    s_b = 16'h5678;
    bus.adc_data_in_p[0 +: DATA_W] = s_a;
    step(4'b0001, 32'd400);
    bus.adc_data_in_p[0 +: DATA_W] = s_b;
    step(4'b0001, 32'd401);
    repeat (4) @(negedge clk);
    chk("t3_overrun", 64'(bus.overrun_p[0]), 64'd1);
    bus.fifo_full_p = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (bus.fifo_wr_en_p) seen = 1'b1;
    end
    chk("t3_wait_wr", 64'(seen), 64'd1);
`ifdef ADC_ARB_OVERRUN_CNT_EN
    chk("t3_pkt", bus.fifo_wr_data_p, {8'd0, 8'h03, 32'd400, s_a});
`else
    chk("t3_pkt", bus.fifo_wr_data_p, {8'd0, 8'h01, 32'd400, s_a});
`endif
    repeat (3) @(negedge clk);

    // pulse on ch3 in its grant cycle
    rand_data();
    s_a = bus.adc_data_in_p[3*DATA_W +: DATA_W];
    step(4'b1000, 32'd500);
    rand_data();
    s_b = bus.adc_data_in_p[3*DATA_W +: DATA_W];
    step(4'b1000, 32'd501);
    chk("t4_old", {bus.fifo_wr_en_p, bus.fifo_wr_data_p[62:0]}, {1'b1, 7'd3, 8'd0, 32'd500, s_a});
    repeat (2) @(negedge clk);
    chk("t4_new", {bus.fifo_wr_en_p, bus.fifo_wr_data_p[62:0]}, {1'b1, 7'd3, 8'd0, 32'd501, s_b});
    chk("t4_no_overrun", 64'(bus.overrun_p), 64'd0);
    repeat (2) @(negedge clk);

    // timekeeper not ready: nothing captured
    bus.timekeeper_ready_p = 1'b0;
    rand_data();
    step(4'b1111, 32'd600);
    step(4'b0101, 32'd601);
    repeat (3) @(negedge clk);
    chk("t5_no_capture", 64'(bus.pending_p), 64'd0);
    bus.timekeeper_ready_p = 1'b1;

    // async reset during the write cycle
    rand_data();
    step(4'b0011, 32'd700);
    @(negedge clk);
    chk("t5_wr_before_rst", 64'(bus.fifo_wr_en_p), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_wr_en",   64'(bus.fifo_wr_en_p), 64'd0);
    chk("t5_rst_pending", 64'(bus.pending_p),    64'd0);
    chk("t5_rst_data",    bus.fifo_wr_data_p,    64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bus.enable_p           = ($urandom_range(0, 9) != 0);
      bus.fifo_full_p        = ($urandom_range(0, 7) == 0);
      bus.timekeeper_ready_p = ($urandom_range(0, 15) != 0);
      rand_data();
      step(NUM_CH'($urandom_range(0, 15) & $urandom_range(0, 15)), 32'($urandom));
    end
    bus.enable_p           = 1'b1;
    bus.fifo_full_p        = 1'b0;
    bus.timekeeper_ready_p = 1'b1;
    repeat (20) @(negedge clk);
    chk("drain_empty", 64'(q.size()), 64'd0);
    chk("drain_pending", 64'(bus.pending_p), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
